// File: rtl/flippy_pkg.sv
// flippy_pkg: constants, spawn FSM states and the LFSR step shared by the FlippyBit column pipeline
package flippy_pkg;
  localparam int LETTER_W = 8;
  localparam int ROWS = 22;
  localparam int PERIOD_W = 26;
  localparam logic [3:0] MAX_LEVEL = 4'd15;
  localparam logic [9:0] SCORE_MAX = 10'd1023;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci tap mask
  localparam logic [LETTER_W-1:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DROP} spawn_state_e;
  function automatic logic [LETTER_W-1:0] lfsr_step(input logic [LETTER_W-1:0] v);
    return {v[LETTER_W-2:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/flippy_spawner_if.sv
// flippy_spawner_if: column-side handshake, pulses and score/level readout of the spawner
interface flippy_spawner_if;
  import flippy_pkg::*;
  logic spawn_req;
  logic correct_pulse;
  logic game_over;
  logic spawn_valid;
  logic [LETTER_W-1:0] spawn_letter;
  logic drop_tick;
  logic [9:0] score;
  logic [3:0] level;
  modport master (
    output spawn_req, correct_pulse, game_over,
    input spawn_valid, spawn_letter, drop_tick, score, level
  );
  modport slave (
    input spawn_req, correct_pulse, game_over,
    output spawn_valid, spawn_letter, drop_tick, score, level
  );
endinterface

// File: rtl/flippy_lfsr8.sv
// flippy_lfsr8: free-running 8-bit Fibonacci LFSR exposing current and next value
module flippy_lfsr8
  import flippy_pkg::*;
#(
  parameter logic [LETTER_W-1:0] SEED = 8'hA5
) (
  input  logic                clock,
  input  logic                reset_signal,
  output logic [LETTER_W-1:0] value_o,
  output logic [LETTER_W-1:0] next_o
);
  logic [LETTER_W-1:0] value_q;
  assign next_o = lfsr_step(value_q);
  assign value_o = value_q;
  always_ff @(posedge clock) value_q <= reset_signal ? SEED : next_o;
endmodule

// File: rtl/flippy_spawner.sv
// flippy_spawner: issues column letters, paces drop ticks and tracks score/level
module flippy_spawner
  import flippy_pkg::*;
#(
  parameter int unsigned TICK_START = 25_000_000,
  parameter int unsigned TICK_MIN = 5_000_000,
  parameter int unsigned TICK_STEP = 2_500_000,
  parameter int unsigned LEVEL_UP_COUNT = 8,
  parameter logic [LETTER_W-1:0] SEED = 8'hA5
) (
  input logic             clock,
  input logic             reset_signal,
  flippy_spawner_if.slave sp
);
  localparam int LW = $clog2(LEVEL_UP_COUNT + 1);
  localparam logic [PERIOD_W-1:0] P_START = PERIOD_W'(TICK_START);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(TICK_MIN);
  localparam logic [PERIOD_W-1:0] P_STEP = PERIOD_W'(TICK_STEP);
  localparam logic [PERIOD_W:0] P_FLOOR = {1'b0, P_MIN} + {1'b0, P_STEP};
  localparam logic [LW-1:0] L_LAST = LW'(LEVEL_UP_COUNT - 1);
  spawn_state_e state_q, state_d;
  logic [LETTER_W-1:0] lfsr, lfsr_next, letter_q, letter_d;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [9:0] score_q, score_d;
  logic [3:0] level_q, level_d;
  logic [LW-1:0] inlvl_q, inlvl_d;
  logic valid_q, valid_d, tick_q, tick_d;
  logic go_issue, hit, wrap, lvl_up;

  flippy_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clock       (clock),
    .reset_signal(reset_signal),
    .value_o     (lfsr),
    .next_o      (lfsr_next)
  );

  always_comb begin
    go_issue = state_q == IDLE && sp.spawn_req && !sp.game_over;
    state_d = state_q == IDLE ? (go_issue ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT_DROP : (sp.spawn_req ? WAIT_DROP : IDLE);
    valid_d = go_issue;
    // a repeat of the previous letter is replaced by the LFSR's next value, which can never repeat too
    letter_d = go_issue ? (lfsr == letter_q ? lfsr_next : lfsr) : letter_q;
    tick_d = !sp.game_over && cnt_q == '0;
    cnt_d = sp.game_over ? cnt_q : (cnt_q == '0 ? period_q - 1'b1 : cnt_q - 1'b1);
    hit = sp.correct_pulse && !sp.game_over;
    wrap = hit && inlvl_q == L_LAST;
    lvl_up = wrap && level_q != MAX_LEVEL;
    score_d = (hit && score_q != SCORE_MAX) ? score_q + 10'd1 : score_q;
    inlvl_d = hit ? (wrap ? '0 : inlvl_q + 1'b1) : inlvl_q;
    level_d = lvl_up ? level_q + 4'd1 : level_q;
    period_d = !lvl_up ? period_q : ({1'b0, period_q} >= P_FLOOR ? period_q - P_STEP : P_MIN);
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      letter_q <= '0;
      tick_q <= 1'b0;
      cnt_q <= P_START - 1'b1;
      period_q <= P_START;
      score_q <= '0;
      level_q <= '0;
      inlvl_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      letter_q <= letter_d;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      score_q <= score_d;
      level_q <= level_d;
      inlvl_q <= inlvl_d;
    end
  end

  assign sp.spawn_valid = valid_q;
  assign sp.spawn_letter = letter_q;
  assign sp.drop_tick = tick_q;
  assign sp.score = score_q;
  assign sp.level = level_q;
endmodule

// File: tb/tb_flippy_spawner.sv
// tb_flippy_spawner: directed and random stimulus against a cycle-level behavioural model of the spawner
module tb_flippy_spawner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] seq [255];
  int idx, rem, cnt;
  bit armed, skip, e_valid, e_tick;
  logic [7:0] e_letter;

  flippy_spawner_if bus();

  flippy_spawner #(
    .TICK_START(10),
    .TICK_MIN(4),
    .TICK_STEP(3),
    .LEVEL_UP_COUNT(2),
    .SEED(8'hA5)
  ) dut (
    .clock       (clk),
    .reset_signal(rst),
    .sp          (bus)
  );

  always #5 clk = ~clk;

  function automatic int lvl_of(input int c);
    return (c / 2 > 15) ? 15 : c / 2;
  endfunction

  function automatic int period_of(input int l);
    int p;
    p = 10 - 3 * l;
    return p < 4 ? 4 : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      idx = 0; rem = 10; cnt = 0; armed = 1; skip = 0;
      e_valid = 0; e_tick = 0; e_letter = 8'h00;
    end else begin
      int lv;
      lv = lvl_of(cnt);
      e_tick = 0;
      e_valid = 0;
      if (!bus.game_over) begin
        rem--;
        if (rem == 0) begin
          e_tick = 1;
          rem = period_of(lv);
        end
      end
      if (armed && bus.spawn_req && !bus.game_over) begin
        e_valid = 1;
        e_letter = (seq[idx % 255] == e_letter) ? seq[(idx + 1) % 255] : seq[idx % 255];
        armed = 0;
        skip = 1;
      end else begin
        if (!skip && !bus.spawn_req) armed = 1;
        skip = 0;
      end
      if (bus.correct_pulse && !bus.game_over) cnt++;
      idx++;
    end
    #1;
    chk("valid", bus.spawn_valid, e_valid);
    chk("letter", bus.spawn_letter, e_letter);
    chk("tick", bus.drop_tick, e_tick);
    chk("score", bus.score, cnt > 1023 ? 1023 : cnt);
    chk("level", bus.level, lvl_of(cnt));
  endtask

  initial begin
    int ticks[$];
    int nval, first;
    logic [7:0] last;
    logic [9:0] s0;
    logic [3:0] l0;
    seq[0] = 8'hA5;
    for (int i = 1; i < 255; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    bus.spawn_req = 0; bus.correct_pulse = 0; bus.game_over = 0;
    repeat (3) cyc();
    rst = 0;
    // drop ticks at 10, 20, 30 cycles after release
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (bus.drop_tick) ticks.push_back(i);
    end
    chk("tick_count", ticks.size(), 3);
    for (int i = 0; i < ticks.size() && i < 3; i++) chk("tick_pos", ticks[i], 10 * (i + 1));
    // six correct answers spread over the countdown, then watch the shortened periods
    for (int i = 0; i < 6; i++) begin
      bus.correct_pulse = 1; cyc();
      bus.correct_pulse = 0; repeat ($urandom_range(1, 5)) cyc();
    end
    chk("score6", bus.score, 6);
    chk("level3", bus.level, 3);
    repeat (30) cyc();
    // held request: one letter per rise
    nval = 0; last = 8'h00;
    for (int i = 0; i < 13; i++) begin
      bus.spawn_req = (i < 6) || (i >= 8 && i < 12);
      cyc();
      if (bus.spawn_valid) begin
        nval++;
        chk("letter_nz", bus.spawn_letter != 8'h00, 1);
        chk("letter_diff", bus.spawn_letter != last, 1);
        last = bus.spawn_letter;
      end
    end
    chk("spawn_count", nval, 2);
    // freeze with activity on every input
    repeat (3) cyc();
    s0 = bus.score; l0 = bus.level;
    bus.game_over = 1;
    for (int i = 0; i < 20; i++) begin
      bus.correct_pulse = $urandom_range(0, 1);
      bus.spawn_req = $urandom_range(0, 1);
      cyc();
      chk("frozen_tick", bus.drop_tick, 0);
      chk("frozen_valid", bus.spawn_valid, 0);
    end
    chk("frozen_score", bus.score, s0);
    chk("frozen_level", bus.level, l0);
    bus.game_over = 0; bus.correct_pulse = 0; bus.spawn_req = 0;
    repeat (15) cyc();
    // reset landing in the ISSUE cycle at level 2
    rst = 1; cyc(); rst = 0;
    bus.correct_pulse = 1; repeat (4) cyc();
    bus.correct_pulse = 0; cyc();
    chk("level2", bus.level, 2);
    bus.spawn_req = 1; cyc();
    chk("issue_before_reset", bus.spawn_valid, 1);
    rst = 1; cyc(); rst = 0;
    chk("valid_after_reset", bus.spawn_valid, 0);
    chk("level_after_reset", bus.level, 0);
    chk("score_after_reset", bus.score, 0);
    bus.spawn_req = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (bus.drop_tick && first == 0) first = i;
    end
    chk("first_tick", first, 10);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.spawn_req = $urandom_range(0, 3) != 0;
      bus.correct_pulse = $urandom_range(0, 3) == 0;
      bus.game_over = $urandom_range(0, 15) == 0;
      cyc();
    end
    // saturation of score and level
    bus.game_over = 0;
    rst = 1; cyc(); rst = 0;
    bus.correct_pulse = 1;
    for (int i = 0; i < 1030; i++) begin
      bus.spawn_req = $urandom_range(0, 1);
      cyc();
    end
    bus.correct_pulse = 0; bus.spawn_req = 0;
    repeat (5) cyc();
    chk("score_sat", bus.score, 1023);
    chk("level_sat", bus.level, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flippy_spawner.md
# flippy_spawner

- Upstream stage of each falling-letter column in FlippyBit.
- Generates the fresh 8-bit target letter a column requests when it (re)starts, with a request/valid handshake.
- Generates the per-row `drop_tick` pulse that advances the column's `ypos`.
- Tracks score and level from the column's `correct` pulses; each level-up shortens the drop period down to a floor.

## Interface

**Parameters**
- `TICK_START`, default 25_000_000: drop period in clock cycles at level 0.
- `TICK_MIN`, default 5_000_000: floor for the drop period.
- `TICK_STEP`, default 2_500_000: period decrement per level-up.
- `LEVEL_UP_COUNT`, default 8: correct answers per level.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

**Ports**
- `clock`  in  1: system clock (CLOCK_50).
- `reset_signal`  in  1: synchronous, active-high reset.
- `spawn_req`  in  1: column requests a new letter; level-sensitive.
- `correct_pulse`  in  1: one-cycle pulse per correct answer.
- `game_over`  in  1: freezes the block while high.
- `spawn_valid`  out  1: one-cycle strobe; `spawn_letter` is valid in this cycle.
- `spawn_letter`  out  8: issued letter; holds its value until the next issue.
- `drop_tick`  out  1: one-cycle pulse; the column moves down one row.
- `score`  out  10: correct-answer count, saturates at 1023.
- `level`  out  4: current level, saturates at 15.

## Operation

**Reset values**
- `spawn_valid`=0, `spawn_letter`=8'h00, `drop_tick`=0, `score`=0, `level`=0.
- LFSR=`SEED`, period=`TICK_START`, countdown=`TICK_START`-1, in-level count=0, FSM=IDLE.

**LFSR**
- 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
- Advances every clock, including while `game_over` is high, so letters depend on player timing.
- Never reaches zero.

**Spawn FSM**
- IDLE: `spawn_req`=1 and `game_over`=0 → ISSUE.
- ISSUE: `spawn_valid`=1 for exactly this cycle. `spawn_letter` takes the current LFSR value; if that value equals the previous `spawn_letter`, it takes the LFSR's next-step value instead. → WAIT_DROP.
- WAIT_DROP: stay until `spawn_req`=0, then → IDLE. A held request yields exactly one letter.

**Drop timer**
- Countdown decrements each cycle while `game_over`=0.
- At 0: `drop_tick`=1 for that cycle and countdown reloads with period-1.
- While `game_over`=1: countdown holds and `drop_tick`=0. Counting resumes from the held value.

**Score and level**
- Each `correct_pulse` with `game_over`=0: `score`+1 (saturating) and in-level count+1.
- When in-level count reaches `LEVEL_UP_COUNT`: it wraps to 0; if `level`<15, `level`+1 and period := max(period-`TICK_STEP`, `TICK_MIN`).
- Pulses while `game_over`=1 are ignored.
- The period is 26 bits wide. Compute the subtraction with an explicit compare so it cannot underflow.

## Timing

- Latency from `spawn_req` to `spawn_valid`: `spawn_req` sampled high at edge N → `spawn_valid` high in cycle N+1. `spawn_letter` updates at the same edge.
- The first `drop_tick` occurs `TICK_START` cycles after reset deasserts, then every `period` cycles.
- A new period takes effect at the next reload only; a countdown already in progress is not shortened.
- `correct_pulse` coinciding with `drop_tick` or `spawn_req`: all are handled independently in the same cycle.
- `game_over` rising in ISSUE: `spawn_valid` still completes its single cycle. It only blocks IDLE→ISSUE.
- `reset_signal` overrides everything in the same edge, including mid-ISSUE and mid-countdown.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package `flippy_pkg` holds:
  - `LETTER_W`=8.
  - `ROWS`=22, shared with the column and display.
  - `MAX_LEVEL`=15.
  - `SCORE_MAX`=1023.
  - The LFSR tap mask.
  - The spawn FSM state enum (IDLE, ISSUE, WAIT_DROP).
- One sub-module, `flippy_lfsr8`. Outputs: current value, and next value computed combinationally for the repeat-avoidance rule.
- Target RTL size: roughly 150–250 lines in total.

## Test plan

Test parameters: `TICK_START`=10, `TICK_MIN`=4, `TICK_STEP`=3, `LEVEL_UP_COUNT`=2, `SEED`=8'hA5.

1. Release reset, `game_over`=0 → `drop_tick` at cycles 10, 20, 30 after release; `score`=0, `level`=0.
2. 2 `correct_pulse`s → `level`=1 and period 7 from the next reload. 4 more pulses → `level`=3; period sequence 10, 7, 4, 4; `score`=6.
3. `spawn_req` held high for 6 cycles, then low, then high again → exactly one `spawn_valid` one cycle after each rise. Each letter is nonzero and differs from the previous letter.
4. `game_over` high for 20 cycles mid-countdown with `correct_pulse` and `spawn_req` applied → no `drop_tick`, no `spawn_valid`, `score`/`level` unchanged. After deassert, the tick arrives after exactly the remaining held count.
5. `reset_signal` asserted in the ISSUE cycle at `level`=2 → next cycle `spawn_valid`=0, `level`=0, `score`=0, and the first tick is 10 cycles after release.
6. 1030 `correct_pulse`s → `score` saturates at 1023 and `level` saturates at 15; no wrap.
